// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, computed LSB first with one
// full-subtractor cell and a borrow flop, behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [WIDTH-1:0]   res_next;
    logic [CNT_W-1:0]   count;
    logic               borrow;
    logic               borrow_next;
    logic               d_bit;
    logic               accept;
    logic               last_step;

    assign last_step = (state == RUN) && (count == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start seen in DONE is accepted without an IDLE gap
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs; the new bit enters the result MSB
    always_comb begin
        d_bit       = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
        res_next    = res_sr >> 1;
        res_next[WIDTH-1] = d_bit;
    end

    // Operand shift registers, borrow flop, partial result and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= bin;
            count  <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            borrow <= borrow_next;
            count  <= count + CNT_W'(1);
        end
    end

    // Visible results change only on the final step, never mid-operation
    always_ff @(posedge clk) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (last_step) begin
            diff <= res_next;
            bout <= borrow_next;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus a random
// sweep compared against plain-arithmetic a - b - bin.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    logic         start1;
    logic         a1;
    logic         b1;
    logic         bin1;
    logic         busy1;
    logic         done1;
    logic         diff1;
    logic         bout1;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] prev_diff;
    logic         prev_bout;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: unsigned arithmetic, result wrapped to W bits
    function automatic logic [W-1:0] modelDiff(input int x, input int y, input int c);
        int r;
        r = x - y - c;
        return r[W-1:0];
    endfunction

    function automatic logic modelBout(input int x, input int y, input int c);
        return (x < y + c);
    endfunction

    // Wait for done after the accept edge; results must hold their old value until then
    task automatic waitDone(output int lat);
        lat = 0;
        for (int c = 1; c <= W + 4; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            checkOutput("hold_diff", diff, prev_diff);
            checkOutput("hold_bout", bout, prev_bout);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
        int lat;
        logic [W-1:0] ed;
        logic eb;
        ed = modelDiff(int'(x), int'(y), int'(c));
        eb = modelBout(int'(x), int'(y), int'(c));
        @(negedge clk);
        a = x; b = y; bin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_accept", busy, 1'b1);
        waitDone(lat);
        checkOutput("latency", lat, W);
        checkOutput("diff", diff, ed);
        checkOutput("bout", bout, eb);
        prev_diff = ed;
        prev_bout = eb;
    endtask

    initial begin
        int lat;
        int done_seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        prev_diff = '0; prev_bout = 1'b0;

        // Reset and quiet idle
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_diff", diff, 0);
        checkOutput("rst_bout", bout, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_diff", diff, 0);

        // Directed operations, including underflow wrap
        applyStimulus(8'h5A, 8'h3C, 1'b0);
        checkOutput("diff_5A_3C", diff, 8'h1E);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", done, 0);
        applyStimulus(8'h00, 8'h01, 1'b0);
        checkOutput("wrap_diff", diff, 8'hFF);
        checkOutput("wrap_bout", bout, 1);
        applyStimulus(8'h80, 8'h7F, 1'b1);
        checkOutput("edge_diff", diff, 8'h00);
        checkOutput("edge_bout", bout, 0);

        // start held through RUN with churning operands, then re-issued in DONE
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= W + 4; c++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        checkOutput("held_latency", lat, W);
        checkOutput("held_diff", diff, 8'h1E);
        checkOutput("held_bout", bout, 0);
        a = 8'h10; b = 8'h01; bin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_done_low", done, 0);
        checkOutput("b2b_busy", busy, 1);
        prev_diff = 8'h1E; prev_bout = 1'b0;
        waitDone(lat);
        checkOutput("b2b_latency", lat, W);
        checkOutput("b2b_diff", diff, 8'h0F);
        checkOutput("b2b_bout", bout, 0);

        // Reset in the third RUN cycle aborts the operation
        @(negedge clk);
        a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_diff", diff, 0);
        checkOutput("abort_bout", bout, 0);
        done_seen = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 0);
        prev_diff = '0; prev_bout = 1'b0;
        applyStimulus(8'hFF, 8'h01, 1'b0);
        checkOutput("after_abort_diff", diff, 8'hFE);

        // WIDTH=1: registered full subtractor, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            int r;
            @(negedge clk);
            a1 = i[2]; b1 = i[1]; bin1 = i[0]; start1 = 1'b1;
            r = int'(i[2]) - int'(i[1]) - int'(i[0]);
            @(posedge clk);
            #1;
            start1 = 1'b0;
            checkOutput("w1_busy", busy1, 1);
            @(posedge clk);
            #1;
            checkOutput("w1_done", done1, 1);
            checkOutput("w1_diff", diff1, r & 1);
            checkOutput("w1_bout", bout1, r < 0);
        end

        // Random sweep
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
